// File: rtl/aes_subbytes_serial.sv
// Iterative AES SubBytes / InvSubBytes stage: substitutes SBOX_LANES bytes of a
// 128-bit state per cycle using a small bank of shared forward and inverse S-boxes.

module aes_sbox_compact (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] m);
        logic [7:0] p;
        logic [7:0] s;
        p = '0;
        s = x;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) p = p ^ s;
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = x;
        for (int i = 1; i < 8; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r;
    endfunction

    logic [7:0] t;

    assign t = ginv(a);
    assign y = t ^ {t[6:0], t[7]} ^ {t[5:0], t[7:6]} ^ {t[4:0], t[7:5]} ^ {t[3:0], t[7:4]} ^ 8'h63;
endmodule

module aes_inv_sbox_compact (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] m);
        logic [7:0] p;
        logic [7:0] s;
        p = '0;
        s = x;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) p = p ^ s;
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = x;
        for (int i = 1; i < 8; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r;
    endfunction

    logic [7:0] t;

    // Undo the affine transform first, then invert in the field.
    assign t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    assign y = ginv(t);
endmodule

module aes_subbytes_serial #(
    parameter int SBOX_LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inv,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam int N  = 16 / SBOX_LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [127:0] LANE_MASK = ~128'h0 << (128 - 8 * SBOX_LANES);

    if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4 &&
        SBOX_LANES != 8 && SBOX_LANES != 16) begin : g_bad_lanes
        $error("aes_subbytes_serial: SBOX_LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                    state;
    logic [CW-1:0]             cnt_p0;
    logic                      inv_p0;
    logic [127:0]              work_p0;
    logic [6:0]                sh;
    logic [127:0]              win;
    logic [8*SBOX_LANES-1:0]   lanes_sub;
    logic [127:0]              ins;
    logic [127:0]              mask;

    // Window of the working state aligned so the active group sits in the top bytes.
    assign sh   = 7'(int'(cnt_p0) * SBOX_LANES * 8);
    assign win  = work_p0 << sh;
    assign ins  = (128'(lanes_sub) << (128 - 8 * SBOX_LANES)) >> sh;
    assign mask = LANE_MASK >> sh;

    for (genvar j = 0; j < SBOX_LANES; j++) begin : g_lane
        logic [7:0] b_in;
        logic [7:0] b_fwd;
        logic [7:0] b_inv;

        assign b_in = win[127-8*j -: 8];

        aes_sbox_compact     u_fwd (.a(b_in), .y(b_fwd));
        aes_inv_sbox_compact u_inv (.a(b_in), .y(b_inv));

        assign lanes_sub[8*SBOX_LANES-1-8*j -: 8] = inv_p0 ? b_inv : b_fwd;
    end

    assign out_data = work_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            cnt_p0    <= '0;
            inv_p0    <= 1'b0;
            work_p0   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        work_p0  <= in_data;
                        inv_p0   <= in_inv;
                        cnt_p0   <= '0;
                        state    <= BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                // one group of SBOX_LANES bytes is substituted per cycle
                BUSY: begin
                    work_p0 <= (work_p0 & ~mask) | ins;
                    if (cnt_p0 == CW'(N - 1)) begin
                        cnt_p0    <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        cnt_p0 <= cnt_p0 + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
